// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback control FSM with
// per-stage en/ready handshake, halt detection, retire counting and stage timeout.
module cpu_sequencer #(
   parameter logic [3:0] OP_HLT = 4'b1111,
   parameter int TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        step,
   output logic        fetch_en,
   input  logic        fetch_ready,
   output logic        decode_en,
   input  logic        decode_ready,
   input  logic [3:0]  op,
   output logic        exec_en,
   input  logic        exec_ready,
   output logic        wb_en,
   input  logic        wb_ready,
   output logic [2:0]  state,
   output logic        busy,
   output logic        halted,
   output logic        timeout_err,
   output logic [15:0] instr_count
);
   typedef enum logic [2:0] {
      IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, WB = 3'd4, HALT = 3'd5, ERR = 3'd6
   } state_t;
   state_t cur, nxt;
   logic [TIMEOUT-1:0] cnt;
   logic [3:0] op_q;
   logic stage, fresh, rdy, hit, waiting, retire;
   assign state = cur;
   always_comb begin
      stage = cur inside {FETCH, DECODE, EXEC, WB};
      fresh = fetch_en | decode_en | exec_en | wb_en;
      rdy = cur == FETCH ? fetch_ready : cur == DECODE ? decode_ready :
            cur == EXEC ? exec_ready : cur == WB ? wb_ready : 1'b0;
      // ready in the en cycle itself is not trusted
      hit = stage && !fresh && rdy;
      waiting = stage && !fresh && !rdy;
      retire = hit && (cur == WB || (cur == EXEC && op_q == OP_HLT));
      nxt = cur;
      case (cur)
         IDLE:    nxt = (run | step) ? FETCH : IDLE;
         FETCH:   nxt = hit ? DECODE : FETCH;
         DECODE:  nxt = hit ? EXEC : DECODE;
         EXEC:    nxt = hit ? (op_q == OP_HLT ? HALT : WB) : EXEC;
         WB:      nxt = hit ? (run ? FETCH : IDLE) : WB;
         default: nxt = cur;
      endcase
      if (waiting && cnt == {{(TIMEOUT-1){1'b1}}, 1'b0}) nxt = ERR;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cur         <= IDLE;
         fetch_en    <= 1'b0;
         decode_en   <= 1'b0;
         exec_en     <= 1'b0;
         wb_en       <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         timeout_err <= 1'b0;
         instr_count <= '0;
         cnt         <= '0;
         op_q        <= '0;
      end else begin
         cur         <= nxt;
         fetch_en    <= nxt == FETCH && nxt != cur;
         decode_en   <= nxt == DECODE && nxt != cur;
         exec_en     <= nxt == EXEC && nxt != cur;
         wb_en       <= nxt == WB && nxt != cur;
         busy        <= nxt inside {FETCH, DECODE, EXEC, WB};
         halted      <= nxt == HALT;
         timeout_err <= nxt == ERR;
         instr_count <= instr_count + 16'(retire);
         cnt         <= nxt != cur ? '0 : waiting ? cnt + TIMEOUT'(1) : cnt;
         op_q        <= (cur == DECODE && hit) ? op : op_q;
      end
   end
endmodule
